// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file x0..x(NREG-1) with a pending-write scoreboard.
// Write-back updates storage and clears the destination's busy bit; issue marks a
// destination busy. When issue and write-back hit the same register on one edge,
// the mark wins, because it is the newer pending write.
// Optional feature macro: REGFILE_WB_BYPASS_EN. It forwards write-back data and the
// busy clear onto the read ports in the same cycle, so reads are write-first.
module reg_file_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            mark_we,
   input  logic [AW-1:0]   mark_rd,
   output logic            busy_any
);

   // The address width must cover exactly NREG registers.
   if (AW != $clog2(NREG)) begin : g_bad_aw
      $error("reg_file_sb: AW must equal clog2(NREG)");
   end

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic            wb_hit;
   logic            mark_hit;

   assign wb_hit   = wb_we && (wb_rd != '0);
   assign mark_hit = mark_we && (mark_rd != '0);

   // Storage: capture write-back data; x0 is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this array is reset on purpose, because every register must read 0 after reset.
         // That prevents the storage from mapping onto a RAM macro. The file is small enough for flops.
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_hit) begin
         // NOTE: sequential state uses non-blocking assignments. Other processes that sample
         // this register on the same edge then see the pre-edge value.
         regs[wb_rd] <= wb_data;
      end
   end

   // Scoreboard next state: the clear is applied first, then the set, so the mark wins.
   always_comb begin
      // NOTE: this default is assigned before any branch. Otherwise the paths that do not
      // write busy_next would infer a latch.
      busy_next = busy;
      if (wb_hit) begin
         busy_next[wb_rd] = 1'b0;
      end
      if (mark_hit) begin
         busy_next[mark_rd] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Read port 1: combinational lookup. Address 0 is forced to zero.
   always_comb begin
      rs1_data = '0;
      rs1_busy = 1'b0;
      if (rs1_addr != '0) begin
         rs1_data = regs[rs1_addr];
         rs1_busy = busy[rs1_addr];
`ifdef REGFILE_WB_BYPASS_EN
         // The bypass is gated with rst_n, so the port still reads 0 while reset is held.
         if (rst_n && wb_hit && (rs1_addr == wb_rd)) begin
            rs1_data = wb_data;
            rs1_busy = mark_hit && (mark_rd == wb_rd);
         end
`endif
      end
   end

   // Read port 2: identical to port 1.
   always_comb begin
      rs2_data = '0;
      rs2_busy = 1'b0;
      if (rs2_addr != '0) begin
         rs2_data = regs[rs2_addr];
         rs2_busy = busy[rs2_addr];
`ifdef REGFILE_WB_BYPASS_EN
         if (rst_n && wb_hit && (rs2_addr == wb_rd)) begin
            rs2_data = wb_data;
            rs2_busy = mark_hit && (mark_rd == wb_rd);
         end
`endif
      end
   end

   // Drain indicator: any register has a pending write. busy[0] is always 0.
   assign busy_any = |busy[NREG-1:1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb. It applies a table of single-edge vectors,
// hand-written multi-cycle sequences, and random traffic scored against an array model.
module tb_reg_file_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            wb_we;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            mark_we;
   logic [AW-1:0]   mark_rd;
   logic            busy_any;

   int n_cmp = 0;
   int n_err = 0;

   reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .mark_we  (mark_we),
      .mark_rd  (mark_rd),
      .busy_any (busy_any)
   );

   always #5 clk = ~clk;

   // Reference model: an architectural register array plus one pending flag per register.
   logic [XLEN-1:0] m_reg  [NREG];
   bit              m_busy [NREG];

   function automatic void model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endfunction

   // Applies one clock edge: the write-back retires, then a same-edge issue re-marks.
   function automatic void model_edge();
      if (wb_we && wb_rd != 0) begin
         m_reg[wb_rd]  = wb_data;
         m_busy[wb_rd] = 1'b0;
      end
      if (mark_we && mark_rd != 0) m_busy[mark_rd] = 1'b1;
   endfunction

   function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
      if (!rst_n || a == 0) return '0;
`ifdef REGFILE_WB_BYPASS_EN
      if (wb_we && wb_rd != 0 && a == wb_rd) return wb_data;
`endif
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (!rst_n || a == 0) return 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
      if (wb_we && wb_rd != 0 && a == wb_rd) return mark_we && (mark_rd == wb_rd);
`endif
      return m_busy[a];
   endfunction

   function automatic logic exp_any();
      for (int i = 1; i < NREG; i++) if (m_busy[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, " rs1_data"}, rs1_data, exp_data(rs1_addr));
      check({tag, " rs2_data"}, rs2_data, exp_data(rs2_addr));
      check({tag, " rs1_busy"}, 32'(rs1_busy), 32'(exp_busy(rs1_addr)));
      check({tag, " rs2_busy"}, 32'(rs2_busy), 32'(exp_busy(rs2_addr)));
      check({tag, " busy_any"}, 32'(busy_any), 32'(exp_any()));
   endtask

   // Advances one rising edge, updates the model, and returns 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [XLEN-1:0] d,
                        input logic mwe, input logic [AW-1:0] mrd,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      wb_we = we; wb_rd = rd; wb_data = d; mark_we = mwe; mark_rd = mrd;
      rs1_addr = a1; rs2_addr = a2;
   endtask

   task automatic idle();
      wb_we = 1'b0; mark_we = 1'b0;
   endtask

   typedef struct {
      logic            wb_we;
      logic [AW-1:0]   wb_rd;
      logic [XLEN-1:0] wb_data;
      logic            mark_we;
      logic [AW-1:0]   mark_rd;
      logic [AW-1:0]   a1;
      logic [AW-1:0]   a2;
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic            b1;
      logic            b2;
      logic            any;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Each vector drives its inputs for one edge. The expected values are the ports
      // on the next cycle, with write-back and mark idle.
      //            we rd  data          mwe mrd a1  a2  d1            d2            b1 b2 any
      vecs[0] = '{1, 5,  32'h0000_1234, 0, 0,  5,  0,  32'h0000_1234, 32'h0,        0, 0, 0};
      vecs[1] = '{1, 0,  32'hDEAD_BEEF, 1, 0,  0,  5,  32'h0,        32'h0000_1234, 0, 0, 0};
      vecs[2] = '{0, 0,  32'h0,         1, 3,  3,  5,  32'h0,        32'h0000_1234, 1, 0, 1};
      vecs[3] = '{1, 3,  32'h0000_0042, 0, 0,  3,  3,  32'h0000_0042, 32'h0000_0042, 0, 0, 0};
      vecs[4] = '{1, 9,  32'h0000_0099, 1, 9,  9,  9,  32'h0000_0099, 32'h0000_0099, 1, 1, 1};
      vecs[5] = '{0, 0,  32'h0,         1, 10, 9,  10, 32'h0000_0099, 32'h0,        1, 1, 1};
      vecs[6] = '{1, 10, 32'h0000_1010, 1, 9,  9,  10, 32'h0000_0099, 32'h0000_1010, 1, 0, 1};
      vecs[7] = '{1, 9,  32'h0000_0077, 0, 0,  9,  10, 32'h0000_0077, 32'h0000_1010, 0, 0, 0};

      // The bench holds reset from time 0 and checks that every output reads 0.
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 5, 31);
      model_reset();
      #3;
      check("reset rs1_data", rs1_data, 32'h0);
      check("reset rs2_data", rs2_data, 32'h0);
      check("reset busy_any", 32'(busy_any), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_data, vecs[i].mark_we, vecs[i].mark_rd,
               vecs[i].a1, vecs[i].a2);
         tick();
         idle();
         #2;
         check($sformatf("vec%0d rs1_data", i), rs1_data, vecs[i].d1);
         check($sformatf("vec%0d rs2_data", i), rs2_data, vecs[i].d2);
         check($sformatf("vec%0d rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].b1));
         check($sformatf("vec%0d rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].b2));
         check($sformatf("vec%0d busy_any", i), 32'(busy_any), 32'(vecs[i].any));
      end

      // Write/read latency: x7 starts at 0.
      drive(1, 7, 32'hA5A5_A5A5, 0, 0, 7, 7);
      #2;
`ifdef REGFILE_WB_BYPASS_EN
      check("lat same-cycle rs1", rs1_data, 32'hA5A5_A5A5);
      check("lat same-cycle rs2", rs2_data, 32'hA5A5_A5A5);
`else
      check("lat same-cycle rs1", rs1_data, 32'h0);
      check("lat same-cycle rs2", rs2_data, 32'h0);
`endif
      tick();
      idle();
      #2;
      check("lat next-cycle rs1", rs1_data, 32'hA5A5_A5A5);
      check("lat next-cycle rs2", rs2_data, 32'hA5A5_A5A5);

      // Asynchronous reset in mid-cycle, with x5 holding data and x4 marked busy.
      drive(1, 5, 32'h0000_1234, 1, 4, 5, 4);
      tick();
      idle();
      #2;
      check("pre-reset rs1_data", rs1_data, 32'h0000_1234);
      check("pre-reset busy_any", 32'(busy_any), 32'h1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async reset rs1_data", rs1_data, 32'h0);
      check("async reset rs2_busy", 32'(rs2_busy), 32'h0);
      check("async reset busy_any", 32'(busy_any), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Scoreboard basic: mark x3, wait two idle cycles, then write back x3.
      drive(0, 0, 0, 1, 3, 0, 3);
      tick();
      idle();
      for (int c = 0; c < 3; c++) begin
         #2;
         check($sformatf("sb busy c%0d", c), 32'(rs2_busy), 32'h1);
         if (c < 2) tick();
      end
      drive(1, 3, 32'h0000_0042, 0, 0, 0, 3);
      #2;
`ifdef REGFILE_WB_BYPASS_EN
      check("sb busy wb-cycle", 32'(rs2_busy), 32'h0);
`else
      check("sb busy wb-cycle", 32'(rs2_busy), 32'h1);
`endif
      tick();
      idle();
      #2;
      check("sb busy after wb", 32'(rs2_busy), 32'h0);
      check("sb rs2_data", rs2_data, 32'h0000_0042);

      // Full sweep: mark x1..x31, then retire them in descending order.
      for (int r = 1; r < NREG; r++) begin
         drive(0, 0, 0, 1, AW'(r), 0, 0);
         tick();
      end
      idle();
      #2;
      check("sweep all marked", 32'(busy_any), 32'h1);
      for (int r = NREG - 1; r >= 1; r--) begin
         drive(1, AW'(r), XLEN'(r * 32'h11), 0, 0, 0, 0);
         tick();
         idle();
         #2;
         if (r == 2) check("sweep busy_any before x1", 32'(busy_any), 32'h1);
         if (r == 1) check("sweep busy_any after x1", 32'(busy_any), 32'h0);
      end
      for (int r = 1; r < NREG; r++) begin
         rs1_addr = AW'(r);
         rs2_addr = AW'(NREG - r);
         #1;
         check($sformatf("sweep rd x%0d", r), rs1_data, XLEN'(r * 32'h11));
         check($sformatf("sweep rd2 x%0d", NREG - r), rs2_data, XLEN'((NREG - r) * 32'h11));
      end

      // Random traffic, checked every cycle against the model before the edge.
      // Addresses are drawn from a small range so that collisions and bypass hits are frequent.
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)));
         #2;
         check_all($sformatf("rand%0d", n));
         tick();
      end
      idle();
      #2;
      check_all("rand final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Integer register file x0..x31 that receives the write-back stage outputs: write data, destination register, write enable.
- Provides two combinational read ports to decode.
- Contains a per-register pending-write scoreboard. Issue marks a destination register busy; the matching write-back clears it. Decode uses the busy flags to stall on unresolved hazards.

Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers; x0 is hardwired to zero
- AW, 5, register address width; must equal clog2(NREG)

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- wb_we  in  1  write-back enable (reg_we_out from the write-back stage)
- wb_rd  in  AW  write-back destination (rd_out from the write-back stage)
- wb_data  in  XLEN  write-back data (write_data from the write-back stage)
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  XLEN  read port 1 data
- rs2_data  out  XLEN  read port 2 data
- rs1_busy  out  1  rs1 has a pending write
- rs2_busy  out  1  rs2 has a pending write
- mark_we  in  1  issue: mark destination pending
- mark_rd  in  AW  issue destination
- busy_any  out  1  OR of all busy bits (used for fence/drain)

Behaviour:
- Reset: asserting rst_n low asynchronously clears all registers and all busy bits to 0. All outputs read 0 while in reset. Deassertion is synchronous to clk.
- Write:
  - On a rising edge with wb_we=1 and wb_rd!=0, regs[wb_rd] <= wb_data.
  - wb_rd==0 is ignored; x0 always reads 0.
- Reads:
  - Combinational from the storage array; no registers on the read path.
  - Address 0 returns 0 regardless of storage contents.
- Scoreboard:
  - busy[mark_rd] <= 1 on an edge with mark_we=1 and mark_rd!=0.
  - busy[wb_rd] <= 0 on an edge with wb_we=1 and wb_rd!=0.
  - Write-back to a register that is not busy is legal: data is written and busy stays 0.
- Simultaneous mark and write-back, same register: mark wins and busy ends 1. This represents a newer pending write issued in the same cycle the older one retires. Data is still written.
- Simultaneous mark and write-back, different registers: both take effect independently.
- rsN_busy reflects the stored busy bit only, with no same-cycle clear bypass. The exception is the bypass described under Optional Feature.
- busy[0] is never set; rs*_busy for address 0 is 0.
- busy_any is a combinational OR of busy[1..NREG-1].
- Latency:
  - A write is visible on a read port one cycle after the capturing edge, unless the bypass is enabled.
  - Busy set or clear is visible the cycle after the edge.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN
- Defined: when wb_we=1, wb_rd!=0 and rsN_addr==wb_rd in the same cycle:
  - rsN_data = wb_data, combinationally.
  - rsN_busy = 0, unless mark_we=1 with mark_rd==wb_rd; that case keeps busy=1, consistent with the mark-wins rule.
  - This gives write-first semantics and zero-cycle write-to-read.
- Not defined:
  - Reads return the stored value, which is the old data during the write cycle.
  - Busy clears one cycle later.
  - Decode must tolerate the one-cycle stall.

Test Plan:
- Reset: write x5=0x1234, then pulse rst_n low mid-cycle (asynchronous). Required: rs1_data for x5 reads 0 immediately; busy_any=0.
- x0 protection: wb_we=1, wb_rd=0, wb_data=0xDEADBEEF; mark_we=1, mark_rd=0. Required: rs1_addr=0 gives rs1_data=0, rs1_busy=0, busy_any=0.
- Write/read latency: wb_we=1, wb_rd=7, wb_data=0xA5A5A5A5 with rs1_addr=rs2_addr=7. Required without the macro: old value 0 during the write cycle, 0xA5A5A5A5 the next cycle. Required with the macro: 0xA5A5A5A5 in the same cycle.
- Scoreboard basic: mark rd=3, then 2 idle cycles, then wb rd=3 with data 0x42.
  - rs2_busy=1 from cycle+1 until the write-back edge.
  - Busy clears the cycle after that edge; with the macro, it clears in the write-back cycle itself.
  - rs2_data reads 0x42.
- Mark/write-back collision:
  - Mark x9 and write back x9 in the same edge: required rs1_busy=1 afterward and data updated.
  - Mark x9 while writing back x10 (x10 previously busy): required x9 busy, x10 clear.
- Full sweep: mark all x1..x31 → busy_any=1. Retire them in descending order with data=index*0x11 → busy_any drops to 0 only after x1 retires; every register reads back index*0x11.
